vga_frame_reader: RTL and testbench

//  Read side of the composer pixel FIFO: pops 24-bit RGB pixels from a show-ahead

---
 rtl/vga_frame_reader.sv | 164 ++++++++++++++++
 tb/tb_vga_frame_reader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_reader.sv
// Read side of the composer pixel FIFO: pops show-ahead RGB pixels, scans them out
// with VGA timing, issues the per-frame request and recovers from FIFO underflow.
module vga_frame_reader #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int SYNC_POL = 0
) (
   input  logic        clk_clk,
   input  logic        reset_reset,
   input  logic [23:0] fifo_q,
   input  logic        fifo_rdempty,
   output logic        fifo_rdreq,
   output logic        fifo_aclr,
   output logic        frame_req,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        vga_blank_n,
   output logic        vga_sync_n,
   output logic        underflow,
   output logic [15:0] underflow_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT_W     = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SYNC_BEG  = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SYNC_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT_W     = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SYNC_BEG  = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SYNC_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic          SYNC_LVL    = 1'(SYNC_POL);

   typedef enum logic [1:0] {
      S_IDLE,
      S_STREAM,
      S_DRAIN
   } state_t;

   state_t        r_state;
   logic [HW-1:0] r_h_cnt;
   logic [VW-1:0] r_v_cnt;
   logic [23:0]   r_rgb;
   logic          r_hs;
   logic          r_vs;
   logic          r_blank_n;
   logic          r_underflow;
   logic [15:0]   r_underflow_cnt;

   logic          w_h_wrap;
   logic          w_active;
   logic          w_hs_on;
   logic          w_vs_on;
   logic          w_frame_start;
   logic          w_vblank_start;
   logic          w_arm;
   logic          w_pop;
   logic [7:0]    w_chan [3];

   assign w_h_wrap       = (r_h_cnt == H_LAST);
   assign w_active       = (r_h_cnt < H_ACT_W) && (r_v_cnt < V_ACT_W);
   assign w_hs_on        = (r_h_cnt >= H_SYNC_BEG) && (r_h_cnt < H_SYNC_END);
   assign w_vs_on        = (r_v_cnt >= V_SYNC_BEG) && (r_v_cnt < V_SYNC_END);
   assign w_frame_start  = (r_h_cnt == '0) && (r_v_cnt == '0);
   assign w_vblank_start = (r_h_cnt == '0) && (r_v_cnt == V_ACT_W);

   // Arming at the frame origin also pops that first pixel, so a streamed frame
   // always starts at pixel (0,0) and carries its full complement of pixels.
   assign w_arm = (r_state == S_IDLE) && w_frame_start && !fifo_rdempty;
   assign w_pop = !reset_reset && w_active && !fifo_rdempty &&
                  ((r_state == S_STREAM) || w_arm);

   assign fifo_rdreq = w_pop;
   assign frame_req  = w_vblank_start;
   assign fifo_aclr  = (r_state == S_DRAIN) && w_vblank_start;

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else begin
         if (w_h_wrap) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
         end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         r_state         <= S_IDLE;
         r_underflow     <= 1'b0;
         r_underflow_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_arm) begin
                  r_state <= S_STREAM;
               end
            end
            S_STREAM: begin
               if (w_active && fifo_rdempty) begin
                  r_state     <= S_DRAIN;
                  r_underflow <= 1'b1;
                  if (r_underflow_cnt != 16'hFFFF) begin
                     r_underflow_cnt <= r_underflow_cnt + 16'd1;
                  end
               end
            end
            S_DRAIN: begin
               if (w_vblank_start) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Pixel, syncs and blank all come from the same cycle's decode.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         r_rgb     <= '0;
         r_hs      <= ~SYNC_LVL;
         r_vs      <= ~SYNC_LVL;
         r_blank_n <= 1'b0;
      end else begin
         r_rgb     <= w_pop ? fifo_q : 24'd0;
         r_hs      <= w_hs_on ? SYNC_LVL : ~SYNC_LVL;
         r_vs      <= w_vs_on ? SYNC_LVL : ~SYNC_LVL;
         r_blank_n <= w_active;
      end
   end

   for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      assign w_chan[gi] = r_rgb[gi*8 +: 8];
   end

   assign vga_b         = w_chan[0];
   assign vga_g         = w_chan[1];
   assign vga_r         = w_chan[2];
   assign vga_hs        = r_hs;
   assign vga_vs        = r_vs;
   assign vga_blank_n   = r_blank_n;
   assign vga_sync_n    = 1'b0;
   assign underflow     = r_underflow;
   assign underflow_cnt = r_underflow_cnt;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Randomized bench for vga_frame_reader on a reduced raster, checked every cycle
// against a frame-level behavioural model plus per-frame literal totals.
module tb_vga_frame_reader;

   localparam int HA = 16, HF = 2, HS = 3, HB = 3;
   localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FT = HT * VT;
   localparam int NFRAMES = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] fifo_q = 24'd0;
   logic        fifo_rdempty = 1'b0;
   logic        fifo_rdreq, fifo_aclr, frame_req;
   logic [7:0]  vga_r, vga_g, vga_b;
   logic        vga_hs, vga_vs, vga_blank_n, vga_sync_n, underflow;
   logic [15:0] underflow_cnt;

   always #5 clk = ~clk;

   vga_frame_reader #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(0)
   ) dut (
      .clk_clk(clk), .reset_reset(rst),
      .fifo_q(fifo_q), .fifo_rdempty(fifo_rdempty),
      .fifo_rdreq(fifo_rdreq), .fifo_aclr(fifo_aclr), .frame_req(frame_req),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
      .vga_sync_n(vga_sync_n), .underflow(underflow), .underflow_cnt(underflow_cnt)
   );

   int vectors = 0;
   int miscompares = 0;

   // Model: position within the frame, streaming mode, expected registered outputs.
   int          t;
   int          frame_no;
   int          mode;      // 0 idle, 1 streaming, 2 draining after underflow
   logic [23:0] m_rgb;
   logic        m_hs, m_vs, m_blank, m_uf;
   int          m_cnt;
   logic [23:0] fifo_data;
   int          f_pops, f_hs, f_vs, f_blank, f_freq, f_aclr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s frame=%0d t=%0d actual=%0h required=%0h", name, frame_no, t, act, exp);
      end
   endtask

   task automatic model_reset();
      t = 0; mode = 0; m_rgb = 24'd0; m_hs = 1'b1; m_vs = 1'b1; m_blank = 1'b0;
      m_uf = 1'b0; m_cnt = 0;
      f_pops = 0; f_hs = 0; f_vs = 0; f_blank = 0; f_freq = 0; f_aclr = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rgb"},    {vga_r, vga_g, vga_b}, 24'd0);
      check({tag, "_hs"},     vga_hs, 1'b1);
      check({tag, "_vs"},     vga_vs, 1'b1);
      check({tag, "_blank"},  vga_blank_n, 1'b0);
      check({tag, "_rdreq"},  fifo_rdreq, 1'b0);
      check({tag, "_aclr"},   fifo_aclr, 1'b0);
      check({tag, "_freq"},   frame_req, 1'b0);
      check({tag, "_uf"},     underflow, 1'b0);
      check({tag, "_ufcnt"},  underflow_cnt, 16'd0);
   endtask

   function automatic logic empty_for(input int f, input int h, input int v);
      case (f)
         0, 1, 2: return 1'b0;
         3:       return (h == 5 && v == 3);
         4:       return (v < 3);
         5:       return (h == HA - 1 && v == VA - 1);
         default: return ($urandom_range(0, 31) == 0);
      endcase
   endfunction

   task automatic end_of_frame();
      $display("frame %0d: pops=%0d frame_req=%0d aclr=%0d underflow_cnt=%0d",
               frame_no, f_pops, f_freq, f_aclr, underflow_cnt);
      check("frame_req_per_frame", f_freq, 1);
      if (frame_no < 3) begin
         check("pops_full_frame", f_pops, HA * VA);
         check("hs_low_clocks", f_hs, HS * VT);
         check("vs_low_clocks", f_vs, VS * HT);
         check("blank_high_clocks", f_blank, HA * VA);
         check("aclr_none", f_aclr, 0);
      end
      if (frame_no == 3) begin
         check("pops_to_underflow", f_pops, 3 * HA + 5);
         check("ufcnt_after_first", underflow_cnt, 16'd1);
         check("aclr_after_drain", f_aclr, 1);
      end
      if (frame_no == 4) begin
         check("pops_idle_frame", f_pops, 0);
         check("aclr_idle_frame", f_aclr, 0);
      end
      if (frame_no == 5) begin
         check("pops_last_px_uf", f_pops, HA * VA - 1);
         check("ufcnt_after_second", underflow_cnt, 16'd2);
         check("aclr_last_px_uf", f_aclr, 1);
      end
      f_pops = 0; f_hs = 0; f_vs = 0; f_blank = 0; f_freq = 0; f_aclr = 0;
      frame_no++;
      t = 0;
   endtask

   task automatic run_cycle();
      int   h, v;
      logic act, in_hs, in_vs, exp_pop, exp_freq, exp_aclr;
      h = t % HT;
      v = t / HT;
      fifo_rdempty = empty_for(frame_no, h, v);
      fifo_q = fifo_data;
      #1;
      act      = (h < HA) && (v < VA);
      in_hs    = (h >= HA + HF) && (h < HA + HF + HS);
      in_vs    = (v >= VA + VF) && (v < VA + VF + VS);
      exp_pop  = act && !fifo_rdempty && (mode == 1 || (mode == 0 && h == 0 && v == 0));
      exp_freq = (h == 0 && v == VA);
      exp_aclr = exp_freq && (mode == 2);

      check("rdreq", fifo_rdreq, exp_pop);
      check("frame_req", frame_req, exp_freq);
      check("aclr", fifo_aclr, exp_aclr);
      check("rgb", {vga_r, vga_g, vga_b}, m_rgb);
      check("hs", vga_hs, m_hs);
      check("vs", vga_vs, m_vs);
      check("blank_n", vga_blank_n, m_blank);
      check("sync_n", vga_sync_n, 1'b0);
      check("underflow", underflow, m_uf);
      check("underflow_cnt", underflow_cnt, 16'(m_cnt));
      if (frame_no == 0 && t == 0) check("first_pop_origin", fifo_rdreq, 1'b1);
      if (frame_no == 0 && t == VA * HT) check("first_freq_lit", frame_req, 1'b1);

      f_pops  += int'(fifo_rdreq);
      f_hs    += int'(!vga_hs);
      f_vs    += int'(!vga_vs);
      f_blank += int'(vga_blank_n);
      f_freq  += int'(frame_req);
      f_aclr  += int'(fifo_aclr);

      if (frame_no == 7 && h == 10 && v == 3) begin
         #2 rst = 1'b1;
         #1 check_reset_outputs("async_rst");
         @(posedge clk);
         #1 check_reset_outputs("held_rst");
         @(posedge clk);
         #1 rst = 1'b0;
         $display("frame %0d: reset applied at h=%0d v=%0d", frame_no, h, v);
         model_reset();
         frame_no = 8;
         return;
      end

      m_rgb   = exp_pop ? fifo_q : 24'd0;
      m_hs    = !in_hs;
      m_vs    = !in_vs;
      m_blank = act;
      case (mode)
         0: if (h == 0 && v == 0 && !fifo_rdempty) mode = 1;
         1: if (act && fifo_rdempty) begin
               m_uf = 1'b1;
               if (m_cnt < 65535) m_cnt++;
               mode = 2;
            end
         default: if (h == 0 && v == VA) mode = 0;
      endcase
      if (exp_pop) fifo_data = 24'($urandom);

      if (t == FT - 1) end_of_frame();
      else t++;
   endtask

   initial begin
      int guard;
      frame_no  = 0;
      fifo_data = 24'($urandom);
      fifo_q    = fifo_data;
      model_reset();
      @(negedge clk);
      #1 check_reset_outputs("por");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      guard = 0;
      while (frame_no < NFRAMES && guard < 20000) begin
         @(negedge clk);
         run_cycle();
         guard++;
      end
      if (frame_no < NFRAMES) begin
         miscompares++;
         $display("FAIL cycle_budget frames_done=%0d required=%0d", frame_no, NFRAMES);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
